// File: rtl/andport_pkg.sv
// Shared types and constants for the andport stimulus sequencer.
package andport_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_e;

  localparam int unsigned NUM_VECTORS    = 4;
  // Bit i is the expected AND output for input vector i = {a,b}.
  localparam logic [3:0]  EXPECTED_TRUTH = 4'b1000;

endpackage

// File: rtl/andport_hold_cnt.sv
// Loadable down-counter with zero flag, used to time how long each vector is held.
module andport_hold_cnt #(
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/andport_stim_seq.sv
// Drives andport through vectors 00,01,10,11 and checks out == a&b after a hold period.
// Optional ANDPORT_SEQ_CAPTURE_EN adds a 4-bit capture of sampled outputs.
module andport_stim_seq
  import andport_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       dut_out,
  output logic       a,
  output logic       b,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_count,
  output logic [1:0] vector_idx
`ifdef ANDPORT_SEQ_CAPTURE_EN
  ,
  output logic [3:0] capture
`endif
);

  localparam int unsigned CNT_W = $clog2(HOLD_CYCLES + 1);

  state_e     state_q, state_d;
  logic [1:0] idx_q, idx_d;
  logic [2:0] err_q, err_d;
  logic       a_q, a_d, b_q, b_d;
  logic       busy_q, busy_d, done_q, done_d, pass_q, pass_d;
  logic       cnt_load, cnt_dec, cnt_zero;
  logic       run_d;
`ifdef ANDPORT_SEQ_CAPTURE_EN
  logic [3:0] cap_q, cap_d;
`endif

  andport_hold_cnt #(
    .CNT_W (CNT_W)
  ) u_hold_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (CNT_W'(HOLD_CYCLES - 1)),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    err_d    = err_q;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
`ifdef ANDPORT_SEQ_CAPTURE_EN
    cap_d    = cap_q;
`endif
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d  = DRIVE;
          idx_d    = '0;
          err_d    = '0;
          cnt_load = 1'b1;
`ifdef ANDPORT_SEQ_CAPTURE_EN
          cap_d    = '0;
`endif
        end
      end
      DRIVE: begin
        if (cnt_zero) state_d = SAMPLE;
        else          cnt_dec = 1'b1;
      end
      SAMPLE: begin
        if (dut_out != EXPECTED_TRUTH[idx_q]) err_d = err_q + 3'd1;
`ifdef ANDPORT_SEQ_CAPTURE_EN
        cap_d[idx_q] = dut_out;
`endif
        if (idx_q == 2'(NUM_VECTORS - 1)) begin
          state_d = DONE;
        end else begin
          state_d  = DRIVE;
          idx_d    = idx_q + 2'd1;
          cnt_load = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Outputs are registered from next-state values so they align with the state they describe.
    run_d  = (state_d == DRIVE) || (state_d == SAMPLE);
    a_d    = run_d & idx_d[1];
    b_d    = run_d & idx_d[0];
    busy_d = run_d;
    done_d = (state_d == DONE);
    pass_d = done_d && (err_d == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      err_q   <= '0;
      a_q     <= 1'b0;
      b_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
`ifdef ANDPORT_SEQ_CAPTURE_EN
      cap_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
      a_q     <= a_d;
      b_q     <= b_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
`ifdef ANDPORT_SEQ_CAPTURE_EN
      cap_q   <= cap_d;
`endif
    end
  end

  assign a          = a_q;
  assign b          = b_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign err_count  = err_q;
  assign vector_idx = idx_q;
`ifdef ANDPORT_SEQ_CAPTURE_EN
  assign capture    = cap_q;
`endif

endmodule

// File: tb/tb_andport_stim_seq.sv
// Bench for andport_stim_seq: two instances (hold 10 and hold 1) driving a table-defined gate model.
module tb_andport_stim_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b0;
  logic start10 = 1'b0, start1 = 1'b0;
  logic [3:0] tbl10 = 4'b1000, tbl1 = 4'b1000;

  logic a10, b10, busy10, done10, pass10, out10;
  logic [2:0] err10;
  logic [1:0] idx10;
  logic a1, b1, busy1, done1, pass1, out1;
  logic [2:0] err1;
  logic [1:0] idx1;
`ifdef ANDPORT_SEQ_CAPTURE_EN
  logic [3:0] cap10, cap1;
`endif

  // Gate under test modelled as a truth table indexed by {a,b}.
  assign out10 = tbl10[{a10, b10}];
  assign out1  = tbl1[{a1, b1}];

  andport_stim_seq #(.HOLD_CYCLES(10)) dut10 (
    .clk(clk), .rst(rst), .start(start10), .dut_out(out10),
    .a(a10), .b(b10), .busy(busy10), .done(done10), .pass(pass10),
    .err_count(err10), .vector_idx(idx10)
`ifdef ANDPORT_SEQ_CAPTURE_EN
    , .capture(cap10)
`endif
  );

  andport_stim_seq #(.HOLD_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .dut_out(out1),
    .a(a1), .b(b1), .busy(busy1), .done(done1), .pass(pass1),
    .err_count(err1), .vector_idx(idx1)
`ifdef ANDPORT_SEQ_CAPTURE_EN
    , .capture(cap1)
`endif
  );

  int unsigned total = 0;
  int unsigned bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Snapshot of one instance's outputs packed {a,b,busy,done,pass,err[2:0],idx[1:0]}.
  function automatic logic [9:0] snap(input int sel);
    if (sel == 0) return {a10, b10, busy10, done10, pass10, err10, idx10};
    else          return {a1, b1, busy1, done1, pass1, err1, idx1};
  endfunction

  // Full run: expected per-cycle vector is j/(H+1); results follow from the truth table.
  task automatic run(input int sel, input logic [3:0] tbl, input int ign_at);
    int unsigned h;
    int unsigned len;
    int unsigned v;
    int unsigned nerr;
    logic [9:0] s;
    h = (sel == 0) ? 10 : 1;
    len = 4 * (h + 1);
    if (sel == 0) begin tbl10 = tbl; start10 = 1'b1; end
    else          begin tbl1  = tbl; start1  = 1'b1; end
    step();
    for (int unsigned j = 0; j < len; j++) begin
      if (j > 0) step();
      v = j / (h + 1);
      s = snap(sel);
      chk($sformatf("h%0d_ab_c%0d", h, j), {30'd0, s[9:8]}, v);
      chk($sformatf("h%0d_idx_c%0d", h, j), {30'd0, s[1:0]}, v);
      chk($sformatf("h%0d_busy_c%0d", h, j), {30'd0, s[7:6]}, 32'd2);
      if (j == 0) chk($sformatf("h%0d_start_clr", h), {29'd0, s[4:2]}, 0);
      if (sel == 0) start10 = (j == ign_at);
      else          start1  = (j == ign_at);
    end
    step();
    nerr = $countones(tbl ^ 4'b1000);
    s = snap(sel);
    chk($sformatf("h%0d_done_ab", h), {30'd0, s[9:8]}, 0);
    chk($sformatf("h%0d_busy_done", h), {30'd0, s[7:6]}, 32'd1);
    chk($sformatf("h%0d_err", h), {29'd0, s[4:2]}, nerr);
    chk($sformatf("h%0d_pass", h), {31'd0, s[5]}, (nerr == 0) ? 1 : 0);
    chk($sformatf("h%0d_idx_done", h), {30'd0, s[1:0]}, 3);
`ifdef ANDPORT_SEQ_CAPTURE_EN
    chk($sformatf("h%0d_capture", h), {28'd0, (sel == 0) ? cap10 : cap1}, tbl);
`endif
    step();
    chk($sformatf("h%0d_done_hold", h), {31'd0, snap(sel)[6]}, 1);
  endtask

  initial begin
    logic [3:0] rt;
    // Reset dominates start.
    rst = 1'b1; start10 = 1'b1; start1 = 1'b1;
    repeat (3) step();
    chk("rst_dut10", {22'd0, snap(0)}, 0);
    chk("rst_dut1", {22'd0, snap(1)}, 0);
    rst = 1'b0; start10 = 1'b0; start1 = 1'b0;
    repeat (3) step();
    chk("idle_dut10", {22'd0, snap(0)}, 0);
    chk("idle_dut1", {22'd0, snap(1)}, 0);

    run(0, 4'b1000, -1);   // good gate
    run(0, 4'b1111, -1);   // stuck-at-1: start while DONE
    run(0, 4'b1000, 15);   // start during run ignored
    run(1, 4'b1000, -1);   // hold of 1
    run(1, 4'b0000, 3);

    // Mid-run reset aborts without done, then a clean run follows.
    tbl10 = 4'b1000; start10 = 1'b1;
    step(); start10 = 1'b0;
    repeat (19) step();
    chk("mid_busy", {31'd0, busy10}, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst", {22'd0, snap(0)}, 0);
`ifdef ANDPORT_SEQ_CAPTURE_EN
    chk("mid_rst_cap", {28'd0, cap10}, 0);
`endif
    run(0, 4'b1000, -1);

    for (int k = 0; k < 6; k++) begin
      rt = 4'($urandom);
      run(k % 2, rt, (k % 2 == 0) ? int'($urandom_range(1, 40)) : -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/andport_stim_seq.md
Name: andport_stim_seq

Overview:
- Upstream stimulus sequencer and in-line checker for the `andport` 2-input AND gate.
- Drives `andport` inputs `a`/`b` through all four input combinations in the order 00, 01, 10, 11.
- Holds each combination for a programmable number of clocks, then samples the gate's `out` and compares it with the expected a&b.
- Reports busy/done, an error count and a pass flag, giving the team a self-checking synthesizable harness around `andport`.

Parameters:
- HOLD_CYCLES, 10, clocks each vector is driven before sampling; legal range 1..255.
- CNT_W, derived $clog2(HOLD_CYCLES+1), width of the hold counter; not user-overridable.

Ports:
- clk  input  1  single system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request to run a full 4-vector sequence.
- dut_out  input  1  `out` of the `andport` instance under test.
- a  output  1  drives `andport.a`.
- b  output  1  drives `andport.b`.
- busy  output  1  high while a sequence is running.
- done  output  1  high from sequence completion until the next start or reset.
- pass  output  1  valid while done; 1 if err_count==0.
- err_count  output  3  number of mismatching vectors in the last run, 0..4.
- vector_idx  output  2  index of the current or last vector; a=vector_idx[1], b=vector_idx[0].

Behaviour:
- Reset: synchronous, active-high, fixed. On any clk edge with rst=1:
  - state=IDLE, a=b=0, busy=0, done=0, pass=0, err_count=0, vector_idx=0, hold counter=0.
  - rst overrides start.
  - rst mid-run aborts the sequence immediately, with no partial done.
- States: IDLE, DRIVE, SAMPLE, DONE.
- IDLE:
  - a=b=0, busy=0.
  - start=1 -> DRIVE; load vector_idx=0, err_count=0, counter=HOLD_CYCLES-1, done=0.
- DRIVE:
  - busy=1; {a,b}=vector_idx, registered and stable for the whole vector.
  - Counter decrements each cycle; when counter==0 -> SAMPLE.
  - DRIVE therefore lasts exactly HOLD_CYCLES cycles.
- SAMPLE (exactly 1 cycle):
  - a/b still held; dut_out compared against a&b.
  - On mismatch, err_count+1; no saturation needed (max 4 fits in 3 bits).
  - If vector_idx==3 -> DONE.
  - Otherwise vector_idx+1, counter=HOLD_CYCLES-1 -> DRIVE.
- DONE:
  - busy=0, done=1, a=b=0.
  - pass=(err_count==0), taking the final SAMPLE update into account (pass is computed from the next-state err_count).
  - vector_idx stays at 3.
  - start=1 -> behaves as start from IDLE: clears done/pass/err_count, enters DRIVE.
- Latency: start sampled at edge k; done=1 after edge k+4*(HOLD_CYCLES+1). With the default of 10, done rises 44 cycles after start.
- start while busy (DRIVE/SAMPLE) is ignored and does not restart the sequence.
- HOLD_CYCLES=1: each vector is 1 DRIVE cycle plus 1 SAMPLE cycle. The counter loads 0 and exits DRIVE after 1 cycle.
- dut_out is assumed combinational from a/b. The hold time (>=1 cycle) guarantees settling before SAMPLE.
- All outputs are registered; no combinational path from start or dut_out to any output.

Optional Feature:
- Macro: ANDPORT_SEQ_CAPTURE_EN.
- Defined:
  - Extra output port capture, 4 bits.
  - In SAMPLE, capture[vector_idx] <= dut_out.
  - Cleared to 0 on rst and on accepted start; held through DONE.
  - A correct `andport` yields capture=4'b1000.
- Undefined:
  - Port and register are absent.
  - All other behaviour is identical.

Decomposition:
- Shared package andport_pkg:
  - state enum (IDLE=2'd0, DRIVE=2'd1, SAMPLE=2'd2, DONE=2'd3);
  - NUM_VECTORS=4;
  - EXPECTED_TRUTH=4'b1000 (bit i = expected out for vector i).
- Sub-module: none required.
  - The hold counter may be split into andport_hold_cnt (load, dec, zero flag) for reuse.
  - Otherwise it stays a single module.

Test Plan:
- Reset: hold rst=1 for 3 cycles with start=1 -> all outputs 0, state IDLE; release rst -> still idle, no run started.
- Good DUT, HOLD_CYCLES=10:
  - pulse start -> a/b read 00, 01, 10, 11, each for 11 cycles;
  - done=1 exactly 44 cycles after start; err_count=0, pass=1;
  - capture=4'b1000 with ANDPORT_SEQ_CAPTURE_EN.
- Faulty DUT (dut_out tied 1) -> err_count=3, pass=0, done=1; capture=4'b1111 if enabled.
- Mid-run reset: start, then assert rst at cycle 20 -> next edge a=b=0, busy=0, done=0, err_count=0; a new start runs a full, clean 44-cycle sequence.
- start pulsed again at cycle 15 of a run -> ignored, done still at cycle 44. start in DONE -> done drops next cycle, new run begins with vector 00.
- HOLD_CYCLES=1, good DUT -> each vector lasts 2 cycles, done 8 cycles after start, pass=1.
